// File: rtl/glb_cfg_initiator.sv
// glb_cfg_initiator: turns single cfg read/write commands into GLB cfg port
// sequences (setup / enable / hold) and returns one response per command.
`default_nettype none

module glb_cfg_initiator #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  if_cfg_wr_en,
  output logic                  if_cfg_wr_clk_en,
  output logic [ADDR_WIDTH-1:0] if_cfg_wr_addr,
  output logic [DATA_WIDTH-1:0] if_cfg_wr_data,
  output logic                  if_cfg_rd_en,
  output logic                  if_cfg_rd_clk_en,
  output logic [ADDR_WIDTH-1:0] if_cfg_rd_addr,
  input  logic [DATA_WIDTH-1:0] if_cfg_rd_data,
  input  logic                  if_cfg_rd_data_valid
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_SETUP = 4'd1,
    WR_EN    = 4'd2,
    WR_HOLD  = 4'd3,
    RD_SETUP = 4'd4,
    RD_EN    = 4'd5,
    RD_WAIT  = 4'd6,
    RD_HOLD  = 4'd7,
    RESP     = 4'd8
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Every output is assigned for the state being entered, so outputs are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_data        <= '0;
      resp_err         <= 1'b0;
      if_cfg_wr_en     <= 1'b0;
      if_cfg_wr_clk_en <= 1'b0;
      if_cfg_wr_addr   <= '0;
      if_cfg_wr_data   <= '0;
      if_cfg_rd_en     <= 1'b0;
      if_cfg_rd_clk_en <= 1'b0;
      if_cfg_rd_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_write) begin
              state            <= WR_SETUP;
              if_cfg_wr_clk_en <= 1'b1;
              if_cfg_wr_addr   <= req_addr;
              if_cfg_wr_data   <= req_data;
            end else begin
              state            <= RD_SETUP;
              if_cfg_rd_clk_en <= 1'b1;
              if_cfg_rd_addr   <= req_addr;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WR_SETUP: begin
          state        <= WR_EN;
          if_cfg_wr_en <= 1'b1;
        end
        WR_EN: begin
          state        <= WR_HOLD;
          if_cfg_wr_en <= 1'b0;
        end
        WR_HOLD: begin
          state            <= RESP;
          if_cfg_wr_clk_en <= 1'b0;
          if_cfg_wr_addr   <= '0;
          if_cfg_wr_data   <= '0;
          resp_valid       <= 1'b1;
          resp_data        <= '0;
          resp_err         <= 1'b0;
        end
        RD_SETUP: begin
          state        <= RD_EN;
          if_cfg_rd_en <= 1'b1;
          wait_cnt     <= 8'd0;
        end
        RD_EN: begin
          if_cfg_rd_en <= 1'b0;
          if (if_cfg_rd_data_valid) begin
            state     <= RD_HOLD;
            resp_data <= if_cfg_rd_data;
            resp_err  <= 1'b0;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A late valid on the last allowed cycle still wins over the timeout.
          if (if_cfg_rd_data_valid) begin
            state     <= RD_HOLD;
            resp_data <= if_cfg_rd_data;
            resp_err  <= 1'b0;
          end else if (wait_cnt == TO_LAST) begin
            state     <= RD_HOLD;
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RD_HOLD: begin
          state            <= RESP;
          if_cfg_rd_clk_en <= 1'b0;
          if_cfg_rd_addr   <= '0;
          resp_valid       <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_glb_cfg_initiator.sv
// tb_glb_cfg_initiator: scoreboard bench driving cfg commands and a GLB read responder.
`default_nettype none

module tb_glb_cfg_initiator;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_data;
  logic          wr_en, wr_clk_en, rd_en, rd_clk_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_data_valid;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW:0] exp_q[$];

  glb_cfg_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_write            (req_write),
    .req_addr             (req_addr),
    .req_data             (req_data),
    .resp_valid           (resp_valid),
    .resp_ready           (resp_ready),
    .resp_data            (resp_data),
    .resp_err             (resp_err),
    .if_cfg_wr_en         (wr_en),
    .if_cfg_wr_clk_en     (wr_clk_en),
    .if_cfg_wr_addr       (wr_addr),
    .if_cfg_wr_data       (wr_data),
    .if_cfg_rd_en         (rd_en),
    .if_cfg_rd_clk_en     (rd_clk_en),
    .if_cfg_rd_addr       (rd_addr),
    .if_cfg_rd_data       (rd_data),
    .if_cfg_rd_data_valid (rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] all_outs();
    return {33'd0, req_ready, resp_valid, resp_err, wr_en, wr_clk_en, rd_en, rd_clk_en,
            resp_data, wr_addr, wr_data, rd_addr};
  endfunction

  always @(negedge clk) begin
    check_eq("en_overlap", {126'd0, wr_en & rd_en, wr_clk_en & rd_clk_en}, 128'd0);
  end

  // vdelay: cycles from rd_en to the GLB valid pulse (-1 = never); stray drives junk valid on writes.
  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int vdelay, input int stall, input logic stray);
    int  cyc, en_cyc, first_cyc, stall_left, exp_lat;
    int  wr_en_n, wr_clk_n, rd_en_n, rd_clk_n, k;
    bit  done, in_time;
    logic [DW:0] exp;
    in_time = (vdelay >= 0) && (vdelay <= TO);
    exp_lat = wr ? 4 : (in_time ? 4 + vdelay : TO + 4);
    exp     = wr ? {DW+1{1'b0}} : (in_time ? {d, 1'b0} : {{DW{1'b0}}, 1'b1});
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = wr ? d : $urandom;
    k = 0;
    while (!req_ready && k < 20) begin tick(); k++; end
    if (!req_ready) begin
      check_eq("accept_wait", 0, 1);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    exp_q.push_back(exp);
    cyc = 1; en_cyc = -1; first_cyc = -1; stall_left = stall; done = 0;
    wr_en_n = 0; wr_clk_n = 0; rd_en_n = 0; rd_clk_n = 0;
    while (!done && cyc < 200) begin
      wr_en_n  += int'(wr_en);
      wr_clk_n += int'(wr_clk_en);
      rd_en_n  += int'(rd_en);
      rd_clk_n += int'(rd_clk_en);
      if (wr_en) begin
        check_eq("wr_addr", wr_addr, a);
        check_eq("wr_data", wr_data, d);
      end
      if (rd_en) begin
        en_cyc = cyc;
        check_eq("rd_addr", rd_addr, a);
      end
      if (!wr && en_cyc >= 0 && vdelay >= 0 && cyc == en_cyc + vdelay) begin
        rd_data_valid = 1'b1; rd_data = d;
      end else if (wr && stray) begin
        rd_data_valid = 1'b1; rd_data = $urandom;
      end else begin
        rd_data_valid = 1'b0; rd_data = $urandom;
      end
      if (resp_valid) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check_eq("resp_latency", cyc, exp_lat);
        end
        check_eq("resp_data", resp_data, exp_q[0][DW:1]);
        check_eq("resp_err", resp_err, exp_q[0][0]);
        check_eq("req_ready_busy", req_ready, 0);
        if (stall_left > 0) begin
          resp_ready = 1'b0;
          stall_left--;
        end else begin
          resp_ready = 1'b1;
          void'(exp_q.pop_front());
          done = 1;
        end
      end
      tick();
      cyc++;
    end
    resp_ready = 1'b0; rd_data_valid = 1'b0;
    if (!done) check_eq("resp_wait", 0, 1);
    check_eq("wr_en_cycles", wr_en_n, wr ? 1 : 0);
    check_eq("wr_clk_en_cycles", wr_clk_n, wr ? 3 : 0);
    check_eq("rd_en_cycles", rd_en_n, wr ? 0 : 1);
    check_eq("rd_clk_en_cycles", rd_clk_n, wr ? 0 : exp_lat - 1);
    check_eq("idle_ready", req_ready, 1);
  endtask

  initial begin
    logic seen_resp;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0; rd_data = '0; rd_data_valid = 1'b0;
    repeat (3) tick();
    check_eq("reset_outputs", all_outs(), 128'd0);
    reset = 1'b1;
    tick();
    check_eq("ready_after_release", req_ready, 1);

    run_txn(1'b1, 12'h010, 32'hDEADBEEF, -1, 0, 1'b0);
    run_txn(1'b0, 12'h020, 32'h12345678, 2, 0, 1'b0);
    run_txn(1'b0, 12'h021, 32'hA5A5_0001, 0, 0, 1'b0);
    run_txn(1'b0, 12'h022, 32'hFFFF_FFFF, -1, 0, 1'b0);
    run_txn(1'b0, 12'h023, 32'hCAFE_F00D, TO, 0, 1'b0);

    // Back-to-back write then read, both stalled on the response side, with stray valids on the write.
    run_txn(1'b1, 12'hABC, 32'h0BAD_CAFE, -1, 5, 1'b1);
    run_txn(1'b0, 12'h123, 32'h5555_AAAA, 3, 5, 1'b0);

    // Stray valid while idle must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      rd_data_valid = 1'b1; rd_data = $urandom;
      tick();
      check_eq("idle_stray", all_outs(), {33'd0, 7'b100_0000, 88'd0});
    end
    rd_data_valid = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_txn(1'(i % 2), 12'($urandom), $urandom, int'($urandom_range(0, TO + 2)),
              int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while a read sits in RD_WAIT.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h055;
    tick();
    req_valid = 1'b0; req_addr = '0;
    repeat (4) tick();
    check_eq("in_rd_wait", {rd_clk_en, rd_en}, 2'b10);
    reset = 1'b0;
    tick();
    check_eq("abort_outputs", all_outs(), 128'd0);
    reset = 1'b1;
    tick();
    check_eq("abort_ready", req_ready, 1);
    seen_resp = 1'b0;
    for (int i = 0; i < TO + 6; i++) begin
      seen_resp |= resp_valid | rd_en | wr_en;
      tick();
    end
    check_eq("abort_no_resp", seen_resp, 0);
    run_txn(1'b1, 12'h077, 32'h0123_4567, -1, 1, 1'b0);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
